// File: rtl/conv_pe_stream.sv
// Streaming KxK convolution PE: line buffers feed a KxK window. Each completed window passes
// through registered products and then a registered sum+bias(+ReLU) that drives the outputs.
module conv_pe_stream #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 8,
  parameter int STRIDE      = 1,
  parameter int DATA_W      = 8,
  parameter int WEIGHT_W    = 8,
  parameter int ACC_W       = 32,
  parameter int RELU        = 0
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_wload,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE+1)-1:0] i_waddr,
  input  logic signed [WEIGHT_W-1:0]                   i_wdata,
  input  logic                                         i_valid,
  input  logic signed [DATA_W-1:0]                     i_data,
  output logic                                         o_valid,
  output logic signed [ACC_W-1:0]                      o_data,
  output logic [$clog2(FM_SIZE)-1:0]                   o_row,
  output logic [$clog2(FM_SIZE)-1:0]                   o_col,
  output logic                                         o_frame_done,
  output logic                                         o_busy
);

  localparam int K   = KERNEL_SIZE;
  localparam int N   = FM_SIZE;
  localparam int S   = STRIDE;
  localparam int KK  = K * K;
  localparam int OUT = (N - K) / S + 1;
  localparam int AW  = $clog2(KK + 1);
  localparam int CW  = $clog2(N);
  localparam int PW  = DATA_W + WEIGHT_W;
  localparam int LBN = (K > 1) ? K - 1 : 1;

  logic [CW-1:0]              r_q, r_d, c_q, c_d;
  logic signed [DATA_W-1:0]   win_q [K][K];
  logic signed [DATA_W-1:0]   win_d [K][K];
  logic signed [DATA_W-1:0]   lb_q [LBN][N];
  logic signed [DATA_W-1:0]   lb_d [LBN][N];
  logic signed [DATA_W-1:0]   col_s [K];
  logic signed [WEIGHT_W-1:0] w_q [KK];
  logic signed [WEIGHT_W-1:0] w_d [KK];
  logic signed [WEIGHT_W-1:0] bias_q, bias_d;
  logic                       new_frame_q, new_frame_d, busy_q, busy_d;
  logic                       v0_q, v0_d, last0_q, last0_d;
  logic [CW-1:0]              row0_q, row0_d, col0_q, col0_d;
  logic signed [PW-1:0]       prod_q [KK];
  logic signed [PW-1:0]       prod_d [KK];
  logic                       v1_q, v1_d, last1_q, last1_d;
  logic [CW-1:0]              row1_q, row1_d, col1_q, col1_d;
  logic                       ov_q, ov_d, ofd_q, ofd_d;
  logic signed [ACC_W-1:0]    od_q, od_d, acc_s, res_s;
  logic [CW-1:0]              orow_q, orow_d, ocol_q, ocol_d;
  logic [31:0]                r32_s, c32_s, roff_s, coff_s, rdiv_s, cdiv_s;
  logic                       hit_s, last_s, first_s, wr_en_s;

  // Output-position decode for the pixel currently presented at (r_q, c_q).
  always_comb begin
    r32_s   = 32'(r_q);
    c32_s   = 32'(c_q);
    roff_s  = r32_s - 32'(K - 1);
    coff_s  = c32_s - 32'(K - 1);
    rdiv_s  = roff_s / 32'(S);
    cdiv_s  = coff_s / 32'(S);
    hit_s   = (r32_s >= 32'(K - 1)) && (c32_s >= 32'(K - 1)) &&
              ((roff_s % 32'(S)) == 32'd0) && ((coff_s % 32'(S)) == 32'd0);
    last_s  = (rdiv_s == 32'(OUT - 1)) && (cdiv_s == 32'(OUT - 1));
    first_s = i_valid && (r_q == {CW{1'b0}}) && (c_q == {CW{1'b0}});
  end

  // Raster counters, line buffers and window shift; everything holds while i_valid is low.
  always_comb begin
    r_d   = r_q;
    c_d   = c_q;
    win_d = win_q;
    lb_d  = lb_q;
    col_s[K-1] = i_data;
    for (int i = 0; i < K - 1; i++) begin
      col_s[i] = lb_q[K-2-i][c_q];
    end
    if (i_valid) begin
      if (c_q == CW'(N - 1)) begin
        c_d = {CW{1'b0}};
        if (r_q == CW'(N - 1)) begin
          r_d = {CW{1'b0}};
        end else begin
          r_d = r_q + CW'(1);
        end
      end else begin
        c_d = c_q + CW'(1);
      end
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][K-1] = col_s[i];
      end
      // lb[k] holds row r-1-k, so it takes the column entry one row newer.
      for (int k = 0; k < K - 1; k++) begin
        lb_d[k][c_q] = col_s[K-1-k];
      end
    end else begin
      r_d = r_q;
    end
  end

  // Stage-0 tag, frame tracking and weight/bias write port.
  always_comb begin
    v0_d    = i_valid && hit_s;
    row0_d  = CW'(rdiv_s);
    col0_d  = CW'(cdiv_s);
    last0_d = last_s;
    if (first_s) begin
      new_frame_d = 1'b1;
    end else if (i_valid && hit_s && last_s) begin
      new_frame_d = 1'b0;
    end else begin
      new_frame_d = new_frame_q;
    end
    // A new frame that starts before the previous frame_done keeps busy asserted.
    if (first_s) begin
      busy_d = 1'b1;
    end else if (ofd_q && !new_frame_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    w_d     = w_q;
    bias_d  = bias_q;
    wr_en_s = i_wload && !busy_q && (i_waddr <= AW'(KK));
    if (wr_en_s) begin
      if (i_waddr == AW'(KK)) begin
        bias_d = i_wdata;
      end else begin
        w_d[i_waddr] = i_wdata;
      end
    end else begin
      bias_d = bias_q;
    end
  end

  // Stage 1: full-precision signed products.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod_d[i*K+j] = PW'(win_q[i][j]) * PW'(w_q[i*K+j]);
      end
    end
    v1_d    = v0_q;
    row1_d  = row0_q;
    col1_d  = col0_q;
    last1_d = last0_q;
  end

  // Stage 2: wrap-around sum plus sign-extended bias, optional ReLU clamp.
  always_comb begin
    acc_s = ACC_W'(bias_q);
    for (int n = 0; n < KK; n++) begin
      acc_s = acc_s + ACC_W'(prod_q[n]);
    end
    if ((RELU != 0) && acc_s[ACC_W-1]) begin
      res_s = {ACC_W{1'b0}};
    end else begin
      res_s = acc_s;
    end
    ov_d  = v1_q;
    ofd_d = v1_q && last1_q;
    if (v1_q) begin
      od_d   = res_s;
      orow_d = row1_q;
      ocol_d = col1_q;
    end else begin
      od_d   = od_q;
      orow_d = orow_q;
      ocol_d = ocol_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q         <= {CW{1'b0}};
      c_q         <= {CW{1'b0}};
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= {DATA_W{1'b0}};
        end
      end
      for (int k = 0; k < LBN; k++) begin
        for (int n = 0; n < N; n++) begin
          lb_q[k][n] <= {DATA_W{1'b0}};
        end
      end
      for (int n = 0; n < KK; n++) begin
        w_q[n]    <= {WEIGHT_W{1'b0}};
        prod_q[n] <= {PW{1'b0}};
      end
      bias_q      <= {WEIGHT_W{1'b0}};
      new_frame_q <= 1'b0;
      busy_q      <= 1'b0;
      v0_q        <= 1'b0;
      row0_q      <= {CW{1'b0}};
      col0_q      <= {CW{1'b0}};
      last0_q     <= 1'b0;
      v1_q        <= 1'b0;
      row1_q      <= {CW{1'b0}};
      col1_q      <= {CW{1'b0}};
      last1_q     <= 1'b0;
      ov_q        <= 1'b0;
      od_q        <= {ACC_W{1'b0}};
      orow_q      <= {CW{1'b0}};
      ocol_q      <= {CW{1'b0}};
      ofd_q       <= 1'b0;
    end else begin
      r_q         <= r_d;
      c_q         <= c_d;
      win_q       <= win_d;
      lb_q        <= lb_d;
      w_q         <= w_d;
      prod_q      <= prod_d;
      bias_q      <= bias_d;
      new_frame_q <= new_frame_d;
      busy_q      <= busy_d;
      v0_q        <= v0_d;
      row0_q      <= row0_d;
      col0_q      <= col0_d;
      last0_q     <= last0_d;
      v1_q        <= v1_d;
      row1_q      <= row1_d;
      col1_q      <= col1_d;
      last1_q     <= last1_d;
      ov_q        <= ov_d;
      od_q        <= od_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      ofd_q       <= ofd_d;
    end
  end

  assign o_valid      = ov_q;
  assign o_data       = od_q;
  assign o_row        = orow_q;
  assign o_col        = ocol_q;
  assign o_frame_done = ofd_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_conv_pe_stream.sv
// Scoreboard bench for conv_pe_stream: 4x4 map (plain and ReLU) sharing one stimulus, plus a 5x5 stride-2 map.
module tb_conv_pe_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, wload, valid_a, valid_b;
  logic [3:0]        waddr;
  logic signed [7:0] wdata, data_a, data_b;

  logic              ov_a, ofd_a, obusy_a, ov_r, ofd_r, obusy_r, ov_b, ofd_b, obusy_b;
  logic signed [31:0] od_a, od_r, od_b;
  logic [1:0]        orow_a, ocol_a, orow_r, ocol_r;
  logic [2:0]        orow_b, ocol_b;

  conv_pe_stream #(.KERNEL_SIZE(3), .FM_SIZE(4), .STRIDE(1), .RELU(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_wload(wload), .i_waddr(waddr), .i_wdata(wdata),
    .i_valid(valid_a), .i_data(data_a), .o_valid(ov_a), .o_data(od_a), .o_row(orow_a),
    .o_col(ocol_a), .o_frame_done(ofd_a), .o_busy(obusy_a));

  conv_pe_stream #(.KERNEL_SIZE(3), .FM_SIZE(4), .STRIDE(1), .RELU(1)) dut_r (
    .i_clk(clk), .i_rst(rst), .i_wload(wload), .i_waddr(waddr), .i_wdata(wdata),
    .i_valid(valid_a), .i_data(data_a), .o_valid(ov_r), .o_data(od_r), .o_row(orow_r),
    .o_col(ocol_r), .o_frame_done(ofd_r), .o_busy(obusy_r));

  conv_pe_stream #(.KERNEL_SIZE(3), .FM_SIZE(5), .STRIDE(2), .RELU(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_wload(wload), .i_waddr(waddr), .i_wdata(wdata),
    .i_valid(valid_b), .i_data(data_b), .o_valid(ov_b), .o_data(od_b), .o_row(orow_b),
    .o_col(ocol_b), .o_frame_done(ofd_b), .o_busy(obusy_b));

  typedef struct {int data; int row; int col; bit last; int cyc;} exp_t;
  exp_t q_a[$], q_r[$], q_b[$];
  exp_t ea, er, eb;
  int   obs_a[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   n_out_a = 0, n_fd_a = 0, n_out_b = 0, n_fd_b = 0;
  int   wm[9];
  int   bm;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference 3x3 convolution; pixel value equals its raster index.
  function automatic int conv_ref(input int n, input int r, input int c);
    int acc;
    acc = bm;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += ((r - 2 + i) * n + (c - 2 + j)) * wm[i*3+j];
    return acc;
  endfunction

  always @(negedge clk) begin
    if (ov_a === 1'b1) begin
      n_out_a++;
      obs_a.push_back(int'(od_a));
      if (ofd_a === 1'b1) n_fd_a++;
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected got data=%0d row=%0d col=%0d expected no output", od_a, orow_a, ocol_a);
      end else begin
        ea = q_a.pop_front();
        if (od_a !== 32'(ea.data) || orow_a !== 2'(ea.row) || ocol_a !== 2'(ea.col) ||
            ofd_a !== ea.last || cyc != ea.cyc) begin
          failures++;
          $display("FAIL a_result got data=%0d row=%0d col=%0d fd=%0b cyc=%0d expected data=%0d row=%0d col=%0d fd=%0b cyc=%0d",
                   od_a, orow_a, ocol_a, ofd_a, cyc, ea.data, ea.row, ea.col, ea.last, ea.cyc);
        end
      end
    end else if (ofd_a !== 1'b0) begin
      checks++; failures++;
      $display("FAIL a_fd_alone got fd=%b expected 0 without o_valid", ofd_a);
    end
  end

  always @(negedge clk) begin
    if (ov_r === 1'b1) begin
      checks++;
      if (q_r.size() == 0) begin
        failures++;
        $display("FAIL r_unexpected got data=%0d expected no output", od_r);
      end else begin
        er = q_r.pop_front();
        if (od_r !== 32'(er.data) || orow_r !== 2'(er.row) || ocol_r !== 2'(er.col) ||
            ofd_r !== er.last || cyc != er.cyc) begin
          failures++;
          $display("FAIL r_result got data=%0d row=%0d col=%0d fd=%0b cyc=%0d expected data=%0d row=%0d col=%0d fd=%0b cyc=%0d",
                   od_r, orow_r, ocol_r, ofd_r, cyc, er.data, er.row, er.col, er.last, er.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ov_b === 1'b1) begin
      n_out_b++;
      if (ofd_b === 1'b1) n_fd_b++;
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected got data=%0d row=%0d col=%0d expected no output", od_b, orow_b, ocol_b);
      end else begin
        eb = q_b.pop_front();
        if (od_b !== 32'(eb.data) || orow_b !== 3'(eb.row) || ocol_b !== 3'(eb.col) ||
            ofd_b !== eb.last || cyc != eb.cyc) begin
          failures++;
          $display("FAIL b_result got data=%0d row=%0d col=%0d fd=%0b cyc=%0d expected data=%0d row=%0d col=%0d fd=%0b cyc=%0d",
                   od_b, orow_b, ocol_b, ofd_b, cyc, eb.data, eb.row, eb.col, eb.last, eb.cyc);
        end
      end
    end
  end

  task automatic send_a(input int npix, input int idle_pct);
    for (int p = 0; p < npix; p++) begin
      int r, c;
      exp_t e;
      while (int'($urandom_range(0, 99)) < idle_pct) begin
        valid_a = 1'b0;
        @(negedge clk);
      end
      r = p / 4; c = p % 4;
      valid_a = 1'b1; data_a = 8'(p);
      if (r >= 2 && c >= 2) begin
        e.data = conv_ref(4, r, c); e.row = r - 2; e.col = c - 2;
        e.last = (r == 3 && c == 3); e.cyc = cyc + 3;
        q_a.push_back(e);
        if (e.data < 0) e.data = 0;
        q_r.push_back(e);
      end
      @(negedge clk);
    end
    valid_a = 1'b0;
  endtask

  task automatic send_b();
    for (int p = 0; p < 25; p++) begin
      int r, c;
      exp_t e;
      r = p / 5; c = p % 5;
      valid_b = 1'b1; data_b = 8'(p);
      if (r >= 2 && c >= 2 && (r - 2) % 2 == 0 && (c - 2) % 2 == 0) begin
        e.data = conv_ref(5, r, c); e.row = (r - 2) / 2; e.col = (c - 2) / 2;
        e.last = (e.row == 1 && e.col == 1); e.cyc = cyc + 3;
        q_b.push_back(e);
      end
      @(negedge clk);
    end
    valid_b = 1'b0;
  endtask

  // Writes all weights and bias, then one out-of-range address that must be ignored.
  task automatic load_weights(input int w, input int b);
    for (int a = 0; a < 10; a++) begin
      wload = 1'b1; waddr = 4'(a); wdata = (a == 9) ? 8'(b) : 8'(w);
      @(negedge clk);
    end
    waddr = 4'd12; wdata = 8'sd77;
    @(negedge clk);
    wload = 1'b0;
  endtask

  task automatic set_model(input int w, input int b);
    for (int i = 0; i < 9; i++) wm[i] = w;
    bm = b;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80 && (q_a.size() != 0 || q_r.size() != 0 || q_b.size() != 0); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_r.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending a=%0d r=%0d b=%0d expected 0", name, q_a.size(), q_r.size(), q_b.size());
      q_a.delete(); q_r.delete(); q_b.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ov_a, ofd_a, obusy_a, od_a, orow_a, ocol_a} !== 39'd0) begin
      failures++;
      $display("FAIL reset_a got v=%b fd=%b busy=%b data=%0d row=%0d col=%0d expected all 0", ov_a, ofd_a, obusy_a, od_a, orow_a, ocol_a);
    end
    checks++;
    if ({ov_b, ofd_b, obusy_b, od_b, orow_b, ocol_b} !== 41'd0) begin
      failures++;
      $display("FAIL reset_b got v=%b fd=%b busy=%b data=%0d expected all 0", ov_b, ofd_b, obusy_b, od_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obusy_a !== 1'b0 || ov_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got busy=%b valid=%b expected 0 0", obusy_a, ov_a);
    end
    set_model(0, 0);
  endtask

  task automatic test_basic();
    int k;
    load_weights(1, 0);
    set_model(1, 0);
    obs_a.delete();
    send_a(16, 0);
    checks++;
    if (obusy_a !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_inflight got %b expected 1", obusy_a);
    end
    k = 0;
    while (ofd_a !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k >= 40) begin
      failures++;
      $display("FAIL basic_frame_done got none within 40 cycles expected pulse");
    end
    @(negedge clk);
    checks++;
    if (obusy_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_after_done got %b expected 0", obusy_a);
    end
    wait_drain("basic");
    checks++;
    if (obs_a.size() != 4 || obs_a[0] != 45 || obs_a[1] != 54 || obs_a[2] != 81 || obs_a[3] != 90) begin
      failures++;
      $display("FAIL basic_values got %p expected 45 54 81 90", obs_a);
    end
  endtask

  task automatic test_stride();
    int o0, f0;
    o0 = n_out_b; f0 = n_fd_b;
    send_b();
    wait_drain("stride");
    checks++;
    if (n_out_b - o0 != 4 || n_fd_b - f0 != 1) begin
      failures++;
      $display("FAIL stride_count got outputs=%0d fd=%0d expected 4 1", n_out_b - o0, n_fd_b - f0);
    end
  endtask

  task automatic test_back_to_back();
    int o0, f0;
    o0 = n_out_a; f0 = n_fd_a;
    send_a(16, 50);
    send_a(16, 50);
    wait_drain("b2b");
    checks++;
    if (n_out_a - o0 != 8 || n_fd_a - f0 != 2) begin
      failures++;
      $display("FAIL b2b_count got outputs=%0d fd=%0d expected 8 2", n_out_a - o0, n_fd_a - f0);
    end
  endtask

  task automatic test_negative();
    load_weights(-1, 5);
    set_model(-1, 5);
    obs_a.delete();
    send_a(16, 0);
    wait_drain("neg");
    checks++;
    if (obs_a.size() == 0 || obs_a[0] != -40) begin
      failures++;
      $display("FAIL neg_first got %p expected first -40", obs_a);
    end
  endtask

  task automatic test_wload_busy();
    load_weights(1, 0);
    set_model(1, 0);
    obs_a.delete();
    fork
      send_a(16, 0);
      begin
        repeat (4) @(negedge clk);
        load_weights(2, 0);
      end
    join
    wait_drain("wl_busy");
    checks++;
    if (obs_a.size() != 4 || obs_a[3] != 90) begin
      failures++;
      $display("FAIL wload_ignored got %p expected last 90", obs_a);
    end
    load_weights(2, 0);
    set_model(2, 0);
    obs_a.delete();
    send_a(16, 0);
    wait_drain("wl_idle");
    checks++;
    if (obs_a.size() != 4 || obs_a[0] != 90 || obs_a[3] != 180) begin
      failures++;
      $display("FAIL wload_applied got %p expected 90 108 162 180", obs_a);
    end
  endtask

  task automatic test_mid_reset();
    send_a(7, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ov_a, ofd_a, obusy_a, od_a, orow_a, ocol_a} !== 39'd0) begin
      failures++;
      $display("FAIL midrst_outputs got v=%b fd=%b busy=%b data=%0d row=%0d col=%0d expected all 0", ov_a, ofd_a, obusy_a, od_a, orow_a, ocol_a);
    end
    rst = 1'b0;
    q_a.delete(); q_r.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ov_a !== 1'b0) begin
        failures++;
        $display("FAIL midrst_no_valid got %b expected 0 at cycle %0d", ov_a, i);
      end
    end
    set_model(0, 0);
    send_a(16, 0);
    wait_drain("zero_weights");
    load_weights(1, 0);
    set_model(1, 0);
    obs_a.delete();
    send_a(16, 0);
    wait_drain("midrst");
    checks++;
    if (obs_a.size() != 4 || obs_a[0] != 45 || obs_a[3] != 90) begin
      failures++;
      $display("FAIL midrst_resend got %p expected 45 54 81 90", obs_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wload = 1'b0; waddr = 4'd0; wdata = 8'sd0;
    valid_a = 1'b0; valid_b = 1'b0; data_a = 8'sd0; data_b = 8'sd0;
    set_model(0, 0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_stride();
    test_back_to_back();
    test_negative();
    test_wload_busy();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
